// File: rtl/uart_periph.sv
// UART peripheral: bus-mapped TXD/RXD/CON registers with independent 8N1 TX and RX engines.
// Build option: define UART_IRQ_EN to enable CON[1:0] interrupt enables and the registered irqout.
module uart_periph #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irqout
);

    localparam logic [31:0] TXD_ADDR  = 32'h4000_0018;
    localparam logic [31:0] RXD_ADDR  = 32'h4000_001C;
    localparam logic [31:0] CON_ADDR  = 32'h4000_0020;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      tx_state_r, tx_state_s;
    logic [15:0] tx_cnt_r, tx_cnt_s;
    logic [2:0]  tx_bit_r, tx_bit_s;
    logic [7:0]  tx_shift_r, tx_shift_s;
    logic        tx_line_r, tx_line_s;
    logic        tx_end_s;
    logic [7:0]  txd_r;
    logic        tx_done_r;

    logic        rx_meta_r, rx_sync_r, rx_prev_r;
    state_t      rx_state_r, rx_state_s;
    logic [15:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]  rx_bit_r, rx_bit_s;
    logic [7:0]  rx_shift_r, rx_shift_s;
    logic        rx_deliver_s;
    logic [7:0]  rxd_r;
    logic        rx_valid_r;
    logic        rx_overrun_r;

    logic        txd_wr_s, con_wr_s, con_rd_s, rxd_rd_s;
    logic        tx_start_s, tx_busy_s;
    logic [1:0]  ie_s;
    logic [5:0]  con_s;
    logic        unused_s;

    assign txd_wr_s   = wr && (addr == TXD_ADDR);
    assign con_wr_s   = wr && (addr == CON_ADDR);
    assign con_rd_s   = rd && (addr == CON_ADDR);
    assign rxd_rd_s   = rd && (addr == RXD_ADDR);
    assign tx_busy_s  = (tx_state_r != ST_IDLE);
    assign tx_start_s = txd_wr_s && !tx_busy_s;
    assign con_s      = {rx_overrun_r, tx_busy_s, rx_valid_r, tx_done_r, ie_s};
    assign UART_TX    = tx_line_r;
    assign unused_s   = ^wdata[31:8];

    // Combinational read mux; unmapped addresses and idle cycles return zero.
    always_comb begin
        rdata = 32'h0000_0000;
        if (rd) begin
            case (addr)
                TXD_ADDR: rdata = {24'h00_0000, txd_r};
                RXD_ADDR: rdata = {24'h00_0000, rxd_r};
                CON_ADDR: rdata = {26'h000_0000, con_s};
                default:  rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // TX next-state: the line value is computed one cycle ahead so UART_TX leaves a flop.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_line_s  = tx_line_r;
        tx_end_s   = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_cnt_s  = 16'd0;
                tx_bit_s  = 3'd0;
                tx_line_s = 1'b1;
                if (tx_start_s) begin
                    tx_state_s = ST_START;
                    tx_shift_s = wdata[7:0];
                    tx_line_s  = 1'b0;
                end else begin
                    tx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = 16'd0;
                    tx_state_s = ST_DATA;
                    tx_line_s  = tx_shift_r[0];
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s = 16'd0;
                    if (tx_bit_r == 3'd7) begin
                        tx_bit_s   = 3'd0;
                        tx_state_s = ST_STOP;
                        tx_line_s  = 1'b1;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        tx_line_s  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = 16'd0;
                    tx_state_s = ST_IDLE;
                    tx_line_s  = 1'b1;
                    tx_end_s   = 1'b1;
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            default: begin
                tx_state_s = ST_IDLE;
                tx_cnt_s   = 16'd0;
                tx_bit_s   = 3'd0;
                tx_line_s  = 1'b1;
            end
        endcase
    end

    // TX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_line_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_line_r  <= tx_line_s;
        end
    end

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= UART_RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX next-state: mid-bit sampling; a start bit that is high at its midpoint is a glitch.
    always_comb begin
        rx_state_s   = rx_state_r;
        rx_cnt_s     = rx_cnt_r;
        rx_bit_s     = rx_bit_r;
        rx_shift_s   = rx_shift_r;
        rx_deliver_s = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                rx_cnt_s = 16'd0;
                rx_bit_s = 3'd0;
                if (rx_prev_r && !rx_sync_r) begin
                    rx_state_s = ST_START;
                end else begin
                    rx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_s = 16'd0;
                    if (rx_sync_r) begin
                        rx_state_s = ST_IDLE;
                    end else begin
                        rx_state_s = ST_DATA;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = 16'd0;
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_bit_s   = 3'd0;
                        rx_state_s = ST_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s     = 16'd0;
                    rx_state_s   = ST_IDLE;
                    rx_deliver_s = rx_sync_r;
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            default: begin
                rx_state_s = ST_IDLE;
                rx_cnt_s   = 16'd0;
                rx_bit_s   = 3'd0;
            end
        endcase
    end

    // RX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
        end
    end

    // Data registers and status flags; a set event always beats a read-clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txd_r        <= 8'h00;
            rxd_r        <= 8'h00;
            tx_done_r    <= 1'b0;
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            if (txd_wr_s) begin
                txd_r <= wdata[7:0];
            end else begin
                txd_r <= txd_r;
            end
            if (rx_deliver_s) begin
                rxd_r <= rx_shift_r;
            end else begin
                rxd_r <= rxd_r;
            end
            if (tx_end_s) begin
                tx_done_r <= 1'b1;
            end else if (con_rd_s) begin
                tx_done_r <= 1'b0;
            end else begin
                tx_done_r <= tx_done_r;
            end
            if (rx_deliver_s) begin
                rx_valid_r <= 1'b1;
            end else if (rxd_rd_s) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
            if (rx_deliver_s && rx_valid_r) begin
                rx_overrun_r <= 1'b1;
            end else if (con_rd_s) begin
                rx_overrun_r <= 1'b0;
            end else begin
                rx_overrun_r <= rx_overrun_r;
            end
        end
    end

`ifdef UART_IRQ_EN
    logic [1:0] ie_r;
    logic       irq_r;

    assign ie_s   = ie_r;
    assign irqout = irq_r;

    // Interrupt enables and the registered level interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_r  <= 2'b00;
            irq_r <= 1'b0;
        end else begin
            if (con_wr_s) begin
                ie_r <= wdata[1:0];
            end else begin
                ie_r <= ie_r;
            end
            irq_r <= (ie_r[0] & tx_done_r) | (ie_r[1] & rx_valid_r);
        end
    end
`else
    logic unused_con_wr_s;

    assign ie_s            = 2'b00;
    assign irqout          = 1'b0;
    assign unused_con_wr_s = con_wr_s;
`endif

endmodule
